// File: rtl/onewire_bidir_sequencer.sv
// onewire_bidir_sequencer
//   Byte-level half-duplex master for a single open-drain bidirectional pin.
//   Runs reset/presence, write-byte and read-byte slot sequences from a
//   valid/ready command port and returns one response per command.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/ready/op/data  command port (op 0=RESET 1=WRITE 2=READ 3=NOP)
//   rsp_valid/ready          response handshake
//   rsp_data, rsp_pres       read byte (LSB first) / presence result
//   busy                     high whenever not IDLE
//   pin_o, pin_oe, pin_i     open-drain pad: pin_o=0, pin_oe pulls low, pin_i readback
module onewire_bidir_sequencer #(
    parameter int unsigned T_RST_LOW  = 480,
    parameter int unsigned T_PRES_SMP = 70,
    parameter int unsigned T_RST_REL  = 410,
    parameter int unsigned T_SLOT     = 70,
    parameter int unsigned T_LOW0     = 60,
    parameter int unsigned T_LOW1     = 6,
    parameter int unsigned T_SAMPLE   = 15,
    parameter int unsigned CNT_W      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_pres,
    output logic       busy,
    output logic       pin_o,
    output logic       pin_oe,
    input  logic       pin_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RST_LOW = 3'd1;
    localparam logic [2:0] S_RST_REL = 3'd2;
    localparam logic [2:0] S_SLOT    = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [1:0]       op_q, op_n;
    logic [7:0]       data_q, data_n;
    logic             rsp_valid_n;
    logic [7:0]       rsp_data_n;
    logic             rsp_pres_n;
    logic             pin_oe_n;
    logic             cmd_ready_n;
    logic             busy_n;
    logic [CNT_W-1:0] low_len_n;
    logic             pin_s1, pin_s2;

    // Open-drain: only ever drive low.
    assign pin_o = 1'b0;

    // Two-flop synchroniser for the asynchronous pad readback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_s1 <= 1'b1;
            pin_s2 <= 1'b1;
        end else begin
            pin_s1 <= pin_i;
            pin_s2 <= pin_s1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            op_q      <= '0;
            data_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_pres  <= 1'b0;
            pin_oe    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            op_q      <= op_n;
            data_q    <= data_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_pres  <= rsp_pres_n;
            pin_oe    <= pin_oe_n;
            cmd_ready <= cmd_ready_n;
            busy      <= busy_n;
        end
    end

    // Next-state logic; outputs are derived from the next state so the
    // registered pin_oe lines up exactly with the state it belongs to.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        op_n        = op_q;
        data_n      = data_q;
        rsp_valid_n = rsp_valid;
        rsp_data_n  = rsp_data;
        rsp_pres_n  = rsp_pres;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_n       = cmd_op;
                    data_n     = cmd_data;
                    cnt_n      = '0;
                    bit_idx_n  = '0;
                    rsp_data_n = '0;
                    rsp_pres_n = 1'b0;
                    case (cmd_op)
                        OP_RESET: state_n = S_RST_LOW;
                        OP_WRITE,
                        OP_READ:  state_n = S_SLOT;
                        default: begin
                            state_n     = S_RESP;
                            rsp_valid_n = 1'b1;
                        end
                    endcase
                end
            end
            S_RST_LOW: begin
                if (cnt == CNT_W'(T_RST_LOW - 1)) begin
                    state_n = S_RST_REL;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_RST_REL: begin
                if (cnt == CNT_W'(T_PRES_SMP - 1)) begin
                    rsp_pres_n = ~pin_s2;
                end
                if (cnt == CNT_W'(T_RST_REL - 1)) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    cnt_n       = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_SLOT: begin
                if (op_q == OP_READ && cnt == CNT_W'(T_SAMPLE - 1)) begin
                    rsp_data_n[bit_idx] = pin_s2;
                end
                if (cnt == CNT_W'(T_SLOT - 1)) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n     = S_RESP;
                        rsp_valid_n = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n     = S_IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: begin
                state_n     = S_IDLE;
                rsp_valid_n = 1'b0;
            end
        endcase

        // Write-0 holds the line low long; write-1 and read slots use the short pulse.
        low_len_n = (op_n == OP_WRITE && !data_n[bit_idx_n]) ? CNT_W'(T_LOW0) : CNT_W'(T_LOW1);

        pin_oe_n    = (state_n == S_RST_LOW) || (state_n == S_SLOT && cnt_n < low_len_n);
        cmd_ready_n = (state_n == S_IDLE) && !rsp_valid_n;
        busy_n      = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_onewire_bidir_sequencer.sv
// Randomised self-checking bench for onewire_bidir_sequencer with a
// cycle-position device model and a pin_oe pulse-width monitor.
module tb_onewire_bidir_sequencer;

    localparam int T_RST_LOW  = 480;
    localparam int T_PRES_SMP = 70;
    localparam int T_RST_REL  = 410;
    localparam int T_SLOT     = 70;
    localparam int T_LOW0     = 60;
    localparam int T_LOW1     = 6;
    localparam int T_SAMPLE   = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_pres;
    logic       busy;
    logic       pin_o;
    logic       pin_oe;
    logic       pin_i;
    logic       dev_pull = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int run   = 0;
    int oe_bad = 0;
    int lows[$];

    // Wired-AND line with pull-up: low if master or device pulls.
    assign pin_i = ~(pin_oe | dev_pull);

    onewire_bidir_sequencer #(
        .T_RST_LOW(T_RST_LOW), .T_PRES_SMP(T_PRES_SMP), .T_RST_REL(T_RST_REL),
        .T_SLOT(T_SLOT), .T_LOW0(T_LOW0), .T_LOW1(T_LOW1), .T_SAMPLE(T_SAMPLE),
        .CNT_W(10)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_pres(rsp_pres),
        .busy(busy), .pin_o(pin_o), .pin_oe(pin_oe), .pin_i(pin_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Measure pin_oe low-pulse widths and flag any drive outside an active op.
    always @(negedge clk) begin
        if (rst) begin
            run = 0;
        end else if (pin_oe) begin
            run++;
        end else if (run > 0) begin
            lows.push_back(run);
            run = 0;
        end
        if (pin_oe && (!busy || rsp_valid)) oe_bad++;
    end

    // Device behaviour at position p cycles after command accept.
    function automatic logic dev_fn(input logic [1:0] op, input int p,
                                    input logic [7:0] mask, input logic pres);
        int b;
        int c;
        dev_fn = 1'b0;
        if (op == 2'd0) begin
            dev_fn = pres && (p >= T_RST_LOW + 15) && (p <= T_RST_LOW + 150);
        end else if (op == 2'd2) begin
            b = p / T_SLOT;
            c = p % T_SLOT;
            if (b < 8 && c <= 40) dev_fn = mask[b[2:0]];
        end
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data,
                          input logic [7:0] mask, input logic pres, input int hold);
        int n;
        bit got;
        int exp_lat;
        logic [7:0] exp_data;
        int exp_lows[$];
        exp_lat  = (op == 2'd0) ? T_RST_LOW + T_RST_REL + 1 : (op == 2'd3) ? 1 : 8 * T_SLOT + 1;
        exp_data = (op == 2'd2) ? ~mask : 8'd0;
        if (op == 2'd0) exp_lows.push_back(T_RST_LOW);
        if (op == 2'd1) for (int i = 0; i < 8; i++) exp_lows.push_back(data[i] ? T_LOW1 : T_LOW0);
        if (op == 2'd2) for (int i = 0; i < 8; i++) exp_lows.push_back(T_LOW1);

        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        lows.delete();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        n = 0;
        got = 0;
        while (n < 2000 && !got) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n++;
            if (n == 1) chk("busy_after_accept", busy, 1);
            if (rsp_valid) got = 1;
            dev_pull = got ? 1'b0 : dev_fn(op, n - 1, mask, pres);
        end
        chk("rsp_latency", n, exp_lat);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_pres", rsp_pres, (op == 2'd0) ? pres : 1'b0);
        chk("pulse_count", lows.size(), exp_lows.size());
        for (int i = 0; i < exp_lows.size() && i < lows.size(); i++)
            chk($sformatf("pulse_w%0d", i), lows[i], exp_lows[i]);

        // Back-pressure: response must hold and no command may be taken.
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, exp_data);
            chk("hold_cmd_ready", cmd_ready, 0);
            cmd_valid = i[0];
            cmd_op    = 2'd3;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_valid", rsp_valid, 0);
        chk("post_hs_ready", cmd_ready, 1);
        chk("post_hs_busy", busy, 0);
    endtask

    initial begin
        int cnt_v;
        logic [1:0] r_op;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pin_oe", pin_oe, 0);
        chk("rst_pin_o", pin_o, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_pres", rsp_pres, 0);
        rst = 1'b0;

        do_cmd(2'd0, 8'h00, 8'h00, 1'b1, 20);   // presence, long back-pressure
        do_cmd(2'd0, 8'h00, 8'h00, 1'b0, 0);    // no presence
        do_cmd(2'd1, 8'hA5, 8'h00, 1'b0, 2);    // write byte
        do_cmd(2'd2, 8'h00, 8'hC3, 1'b0, 1);    // read byte -> 0x3C
        do_cmd(2'd3, 8'h00, 8'h00, 1'b0, 3);    // NOP

        for (int k = 0; k < 8; k++) begin
            r_op = 2'($urandom_range(0, 3));
            do_cmd(r_op, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 5)));
        end

        // Reset in the middle of a write-0 low phase.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (190) @(negedge clk);
        chk("midop_pin_oe_before", pin_oe, 1);
        #1 rst = 1'b1;
        #1;
        chk("midop_pin_oe_async", pin_oe, 0);
        chk("midop_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midop_cmd_ready", cmd_ready, 1);
        cnt_v = 0;
        repeat (700) begin
            @(negedge clk);
            if (rsp_valid || pin_oe) cnt_v++;
        end
        chk("midop_no_rsp", cnt_v, 0);

        chk("oe_outside_op", oe_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
